// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and a constant
// ceil-log2 helper used to size counters from parameters.
package btn_debounce_pulse_pkg;

   typedef enum logic [1:0] {
      StIdle        = 2'd0,
      StPressWait   = 2'd1,
      StPressed     = 2'd2,
      StReleaseWait = 2'd3
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned     res  = 0;
      longint unsigned span = 1;
      while (span < longint'(value)) begin
         span = span << 1;
         res++;
      end
      return res;
   endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button-side signal bundle: raw button in, debounced level and press/release strobes out.
interface btn_debounce_pulse_if;

   logic btn_in;
   logic btn_level;
   logic pulse;
   logic rel_pulse;

   modport master (
      output btn_in,
      input  btn_level,
      input  pulse,
      input  rel_pulse
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output pulse,
      output rel_pulse
   );

endinterface

// File: rtl/btn_debounce_pulse_sync_ff.sv
// N-flop synchroniser for a single asynchronous input, asynchronously reset to 0.
module btn_debounce_pulse_sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchroniser, 4-state debounce FSM, registered level and strobes.
// Define BTN_AUTO_REPEAT_EN to add auto-repeat press pulses while the button is held.
module btn_debounce_pulse
   import btn_debounce_pulse_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input logic                   clk,
   input logic                   reset,
   btn_debounce_pulse_if.slave   bus
);

   localparam int unsigned      CNT_W   = clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit               Direct  = (DEBOUNCE_CYCLES == 1);

   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_rpt
      $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
   end

   logic             btn_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic             rel_q, rel_d;
   logic             press_fire;
   logic             rpt_fire;

   btn_debounce_pulse_sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (bus.btn_in),
      .q_o   (btn_s)
   );

   // The transition fires on the DEBOUNCE_CYCLES-th consecutive agreeing sample.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      rel_d      = 1'b0;
      press_fire = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (btn_s) begin
               if (Direct) begin
                  state_d    = StPressed;
                  level_d    = 1'b1;
                  press_fire = 1'b1;
               end else begin
                  state_d = StPressWait;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         StPressWait: begin
            if (!btn_s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d    = StPressed;
               cnt_d      = '0;
               level_d    = 1'b1;
               press_fire = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPressed: begin
            cnt_d = '0;
            if (!btn_s) begin
               if (Direct) begin
                  state_d = StIdle;
                  level_d = 1'b0;
                  rel_d   = 1'b1;
               end else begin
                  state_d = StReleaseWait;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         StReleaseWait: begin
            if (btn_s) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StIdle;
               cnt_d   = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
      pulse_d = press_fire | rpt_fire;
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam int unsigned      RptMax     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                             : REPEAT_PERIOD;
   localparam int unsigned      RPT_W      = clog2(RptMax + 1);
   localparam logic [RPT_W-1:0] DelayLast  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PeriodLast = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_armed_q, rpt_armed_d;

   // Counts only while staying in PRESSED; armed selects the period once the delay has elapsed.
   always_comb begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
      rpt_fire    = 1'b0;
      if (state_q == StPressed && btn_s) begin
         rpt_armed_d = rpt_armed_q;
         if (rpt_cnt_q == (rpt_armed_q ? PeriodLast : DelayLast)) begin
            rpt_fire    = 1'b1;
            rpt_armed_d = 1'b1;
         end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rpt_cnt_q   <= '0;
         rpt_armed_q <= 1'b0;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_armed_q <= rpt_armed_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         rel_q   <= rel_d;
      end
   end

   assign bus.btn_level = level_q;
   assign bus.pulse     = pulse_q;
   assign bus.rel_pulse = rel_q;

endmodule
